// File: rtl/header_loader.sv
// Job intake for the hashing controller: loads header/target words,
// owns the nonce and sequences begin_hash/quit_hash with job status.
module header_loader #(
  parameter logic [31:0] MAX_NONCE = 32'hFFFF_FFFF
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         wr_valid,
  input  logic [31:0]  wr_data,
  output logic         wr_ready,
  input  logic         job_abort,
  input  logic         job_clear,
  input  logic         job_resume,
  input  logic         increment,
  input  logic         hash_done,
  input  logic         valid_hash_flag,
  output logic         begin_hash,
  output logic         quit_hash,
  output logic [511:0] msg_block1,
  output logic [127:0] blk2_tail,
  output logic [255:0] target,
  output logic [31:0]  nonce,
  output logic [31:0]  found_nonce,
  output logic         job_found,
  output logic         job_exhausted,
  output logic         busy
);

  typedef enum logic [2:0] {
    LOAD, START, RUN, FOUND, EXH, QUIT
  } state_t;

  state_t      state, state_n;
  logic [4:0]  idx, idx_n;
  logic [31:0] nonce_n, found_n;
  logic        exh_first;
  logic        accept;
  logic [2:0]  tidx;
  logic [31:0] hdr [19];
  logic [31:0] tgt [8];

  assign accept = (state == LOAD) && wr_valid && !job_abort;
  // target words live at idx 20..27; low bits minus 4 gives 0..7
  assign tidx   = idx[2:0] - 3'd4;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    nonce_n = nonce;
    found_n = found_nonce;
    if (job_abort) begin
      // a second abort in QUIT must not stretch the quit pulse
      state_n = (state == QUIT) ? LOAD : QUIT;
      idx_n   = '0;
    end else begin
      case (state)
        LOAD: begin
          if (wr_valid) begin
            if (idx == 5'd19) nonce_n = wr_data;
            if (idx == 5'd27) begin
              state_n = START;
              idx_n   = '0;
            end else begin
              idx_n = idx + 5'd1;
            end
          end
        end
        START: state_n = RUN;
        RUN: begin
          if (hash_done && valid_hash_flag) begin
            found_n = nonce;
            state_n = FOUND;
          end else if (increment) begin
            if (nonce != MAX_NONCE) nonce_n = nonce + 32'd1;
            else state_n = EXH;
          end
        end
        FOUND: begin
          if (job_resume) begin
            if (nonce != MAX_NONCE) begin
              nonce_n = nonce + 32'd1;
              state_n = START;
            end else begin
              state_n = EXH;
            end
          end else if (job_clear) begin
            state_n = QUIT;
          end
        end
        EXH: if (job_clear) state_n = QUIT;
        QUIT: begin
          state_n = LOAD;
          idx_n   = '0;
        end
        default: state_n = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= LOAD;
      idx         <= '0;
      nonce       <= '0;
      found_nonce <= '0;
      exh_first   <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      nonce       <= nonce_n;
      found_nonce <= found_n;
      exh_first   <= (state_n == EXH) && (state != EXH);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < 19; i++) hdr[i] <= '0;
      for (int i = 0; i < 8; i++)  tgt[i] <= '0;
    end else if (accept) begin
      if (idx < 5'd19)       hdr[idx]  <= wr_data;
      else if (idx >= 5'd20) tgt[tidx] <= wr_data;
    end
  end

  always_comb begin
    msg_block1 = '0;
    target     = '0;
    for (int i = 0; i < 16; i++)
      msg_block1[511-32*i -: 32] = hdr[i];
    for (int i = 0; i < 8; i++)
      target[255-32*i -: 32] = tgt[i];
  end

  assign blk2_tail     = {hdr[16], hdr[17], hdr[18], nonce};
  assign wr_ready      = (state == LOAD);
  assign begin_hash    = (state == START);
  assign quit_hash     = (state == QUIT) || (state == EXH && exh_first);
  assign job_found     = (state == FOUND);
  assign job_exhausted = (state == EXH);
  assign busy          = (state == START) || (state == RUN);

endmodule

// File: tb/tb_header_loader.sv
// Bench for header_loader: scoreboarded begin_hash snapshots,
// table-driven RUN/FOUND vectors and hand-written corner sequences.
module tb_header_loader;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic wr_valid = 1'b0;
  logic [31:0] wr_data = '0;
  logic job_abort = 1'b0, job_clear = 1'b0, job_resume = 1'b0;
  logic increment = 1'b0, hash_done = 1'b0, valid_hash_flag = 1'b0;

  logic wr_ready, begin_hash, quit_hash, job_found, job_exhausted, busy;
  logic [511:0] msg_block1;
  logic [127:0] blk2_tail;
  logic [255:0] target;
  logic [31:0] nonce, found_nonce;

  logic wr_ready7, begin_hash7, quit_hash7, job_found7, job_exhausted7, busy7;
  logic [511:0] msg_block17;
  logic [127:0] blk2_tail7;
  logic [255:0] target7;
  logic [31:0] nonce7, found_nonce7;

  always #5 clk = ~clk;

  header_loader dut (
    .clk(clk), .n_rst(n_rst), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .job_abort(job_abort), .job_clear(job_clear),
    .job_resume(job_resume), .increment(increment),
    .hash_done(hash_done), .valid_hash_flag(valid_hash_flag),
    .begin_hash(begin_hash), .quit_hash(quit_hash),
    .msg_block1(msg_block1), .blk2_tail(blk2_tail), .target(target),
    .nonce(nonce), .found_nonce(found_nonce), .job_found(job_found),
    .job_exhausted(job_exhausted), .busy(busy)
  );

  header_loader #(.MAX_NONCE(32'h0000_0007)) dut7 (
    .clk(clk), .n_rst(n_rst), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready7), .job_abort(job_abort), .job_clear(job_clear),
    .job_resume(job_resume), .increment(increment),
    .hash_done(hash_done), .valid_hash_flag(valid_hash_flag),
    .begin_hash(begin_hash7), .quit_hash(quit_hash7),
    .msg_block1(msg_block17), .blk2_tail(blk2_tail7), .target(target7),
    .nonce(nonce7), .found_nonce(found_nonce7), .job_found(job_found7),
    .job_exhausted(job_exhausted7), .busy(busy7)
  );

  typedef struct {
    logic [31:0] w0;
    logic [31:0] tail;
    logic [31:0] t0;
  } exp_t;

  typedef struct {
    bit          inc, hd, vf, res, clr;
    logic [31:0] nonce, fn;
    bit          found, exh, busy, quit;
  } vec_t;

  exp_t sb[$];
  vec_t tv[9];
  int checks = 0, failures = 0;
  int nbeg = 0, nquit = 0, nquit7 = 0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", n, a, e);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (n_rst) begin
      if (begin_hash) begin
        nbeg++;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL begin_unexpected act=1 exp=0");
        end else begin
          e = sb.pop_front();
          chk("sb_word0", msg_block1[511:480], e.w0);
          chk("sb_nonce", blk2_tail[31:0], e.tail);
          chk("sb_target0", target[255:224], e.t0);
        end
      end
      if (quit_hash) nquit++;
      if (quit_hash7) nquit7++;
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in;
    wr_valid = 0; wr_data = '0; job_abort = 0; job_clear = 0;
    job_resume = 0; increment = 0; hash_done = 0; valid_hash_flag = 0;
  endtask

  task automatic do_reset;
    clr_in();
    n_rst = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    sb.delete();
    nbeg = 0; nquit = 0; nquit7 = 0;
    n_rst = 1;
  endtask

  task automatic load(input logic [31:0] base, input logic [31:0] n0,
                      input bit gaps);
    int bad = 0;
    exp_t e;
    for (int i = 0; i < 28; i++) begin
      if (i == 27) begin
        chk("no_early_begin", {31'b0, busy}, 0);
        e.w0 = base; e.tail = n0; e.t0 = base + 32'd20;
        sb.push_back(e);
      end
      wr_valid = 1;
      wr_data = (i == 19) ? n0 : base + 32'(i);
      if (!wr_ready) bad++;
      step();
      if (gaps) begin
        wr_valid = 0;
        wr_data = 32'hDEAD_BEEF;
        step();
      end
    end
    wr_valid = 0;
    if (!gaps) step();
    chk("wr_ready_load", 32'(bad), 0);
  endtask

  initial begin
    exp_t e;
    // inc hd vf res clr | nonce fn found exh busy quit
    tv[0] = '{1,0,0,0,0, 32'd6, 32'd0, 0,0,1,0};
    tv[1] = '{0,0,0,0,0, 32'd6, 32'd0, 0,0,1,0};
    tv[2] = '{1,0,0,0,0, 32'd7, 32'd0, 0,0,1,0};
    tv[3] = '{1,0,0,0,0, 32'd8, 32'd0, 0,0,1,0};
    tv[4] = '{0,1,0,0,0, 32'd8, 32'd0, 0,0,1,0};
    tv[5] = '{1,1,1,0,0, 32'd8, 32'd8, 1,0,0,0};
    tv[6] = '{0,0,0,0,0, 32'd8, 32'd8, 1,0,0,0};
    tv[7] = '{0,0,0,0,1, 32'd8, 32'd8, 0,0,0,1};
    tv[8] = '{0,0,0,0,0, 32'd8, 32'd8, 0,0,0,0};

    do_reset();
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_begin", begin_hash, 0);
    chk("rst_quit", quit_hash, 0);
    chk("rst_found", job_found, 0);
    chk("rst_exh", job_exhausted, 0);
    chk("rst_busy", busy, 0);
    chk("rst_nonce", nonce, 0);
    chk("rst_found_nonce", found_nonce, 0);

    load(32'h1000_0000, 32'd5, 0);
    chk("t1_nbeg", 32'(nbeg), 1);
    chk("t1_busy", busy, 1);
    chk("t1_w0", msg_block1[511:480], 32'h1000_0000);
    chk("t1_w15", msg_block1[31:0], 32'h1000_000F);
    chk("t1_w16", blk2_tail[127:96], 32'h1000_0010);
    chk("t1_nonce", blk2_tail[31:0], 32'd5);
    chk("t1_tgt0", target[255:224], 32'h1000_0014);
    chk("t1_tgt7", target[31:0], 32'h1000_001B);

    for (int i = 0; i < 9; i++) begin
      increment = tv[i].inc; hash_done = tv[i].hd;
      valid_hash_flag = tv[i].vf; job_resume = tv[i].res;
      job_clear = tv[i].clr;
      step();
      clr_in();
      chk($sformatf("vec%0d_nonce", i), nonce, tv[i].nonce);
      chk($sformatf("vec%0d_fn", i), found_nonce, tv[i].fn);
      chk($sformatf("vec%0d_found", i), job_found, tv[i].found);
      chk($sformatf("vec%0d_exh", i), job_exhausted, tv[i].exh);
      chk($sformatf("vec%0d_busy", i), busy, tv[i].busy);
      chk($sformatf("vec%0d_quit", i), quit_hash, tv[i].quit);
      chk($sformatf("vec%0d_begin", i), begin_hash, 0);
    end
    chk("t1_nquit", 32'(nquit), 1);
    chk("t1_nbeg_end", 32'(nbeg), 1);
    chk("t1_load", wr_ready, 1);

    do_reset();
    load(32'h2000_0000, 32'd5, 1);
    chk("t2_nbeg", 32'(nbeg), 1);
    chk("t2_w7", msg_block1[287:256], 32'h2000_0007);
    chk("t2_w16", blk2_tail[127:96], 32'h2000_0010);
    chk("t2_tgt0", target[255:224], 32'h2000_0014);
    hash_done = 1; valid_hash_flag = 1;
    step();
    clr_in();
    chk("t2_found", job_found, 1);
    chk("t2_fn", found_nonce, 32'd5);
    e.w0 = 32'h2000_0000; e.tail = 32'd6; e.t0 = 32'h2000_0014;
    sb.push_back(e);
    job_resume = 1;
    step();
    clr_in();
    chk("t2_resume_nonce", nonce, 32'd6);
    chk("t2_resume_found", job_found, 0);
    chk("t2_resume_busy", busy, 1);
    step();
    chk("t2_nbeg2", 32'(nbeg), 2);
    job_abort = 1;
    step();
    clr_in();
    chk("t2_abort_quit", quit_hash, 1);
    chk("t2_abort_busy", busy, 0);
    step();
    chk("t2_abort_load", wr_ready, 1);
    chk("t2_nquit", 32'(nquit), 1);

    do_reset();
    load(32'h3000_0000, 32'd6, 0);
    increment = 1;
    step();
    clr_in();
    chk("t3_nonce7", nonce7, 32'd7);
    chk("t3_exh_early", job_exhausted7, 0);
    increment = 1;
    step();
    clr_in();
    chk("t3_exh", job_exhausted7, 1);
    chk("t3_exh_quit", quit_hash7, 1);
    chk("t3_nonce_hold", nonce7, 32'd7);
    step();
    chk("t3_exh_quit_once", quit_hash7, 0);
    chk("t3_exh_level", job_exhausted7, 1);
    chk("t3_nquit7_a", 32'(nquit7), 1);
    job_clear = 1;
    step();
    clr_in();
    chk("t3_clear_quit", quit_hash7, 1);
    chk("t3_clear_exh", job_exhausted7, 0);
    step();
    chk("t3_load", wr_ready7, 1);
    chk("t3_nquit7_b", 32'(nquit7), 2);

    do_reset();
    for (int i = 0; i < 10; i++) begin
      wr_valid = 1;
      wr_data = 32'h5000_0000 + 32'(i);
      step();
    end
    job_abort = 1; wr_valid = 1; wr_data = 32'h5000_000A;
    step();
    clr_in();
    chk("t4_abort_quit", quit_hash, 1);
    chk("t4_abort_ready", wr_ready, 0);
    step();
    chk("t4_abort_quit_end", quit_hash, 0);
    chk("t4_abort_load", wr_ready, 1);
    chk("t4_nquit", 32'(nquit), 1);
    load(32'h4000_0000, 32'd9, 0);
    chk("t4_nbeg", 32'(nbeg), 1);
    chk("t4_nquit_b", 32'(nquit), 1);
    chk("t4_w9", msg_block1[223:192], 32'h4000_0009);
    chk("t4_tgt3", target[159:128], 32'h4000_0017);
    increment = 1;
    step();
    clr_in();
    chk("t4_nonce", nonce, 32'd10);
    #2;
    n_rst = 0;
    #1;
    chk("t4_rst_ready", wr_ready, 1);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_begin", begin_hash, 0);
    chk("t4_rst_quit", quit_hash, 0);
    chk("t4_rst_found", job_found, 0);
    chk("t4_rst_exh", job_exhausted, 0);
    chk("t4_rst_nonce", nonce, 0);
    chk("t4_rst_fn", found_nonce, 0);
    chk("t4_rst_w0", msg_block1[511:480], 0);
    chk("t4_rst_tgt0", target[255:224], 0);
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
